wb_history_fwd: RTL and testbench

//   Parametrised writeback history buffer for the 3PA pipeline; successor to the single-stage delayed-WB register.

---
 rtl/wb_history_fwd.sv | 82 ++++++++
 tb/tb_wb_history_fwd.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_history_fwd.sv
// Writeback history buffer: keeps the last DEPTH retired writebacks and offers
// NREAD combinational forwarding lookups, youngest match first.
module wb_history_fwd #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 2,
  parameter int NREAD  = 2,
  parameter bit BYPASS = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_whf_stall,
  input  logic                   i_whf_flush,
  input  logic [4:0]             i_whf_rdst,
  input  logic                   i_whf_reg_write_rf,
  input  logic [WIDTH-1:0]       i_whf_mux,
  input  logic [NREAD*5-1:0]     i_whf_rs,
  output logic [NREAD-1:0]       o_whf_hit,
  output logic [NREAD*WIDTH-1:0] o_whf_data,
  output logic [4:0]             o_whf_rdst,
  output logic                   o_whf_reg_write_rf,
  output logic [WIDTH-1:0]       o_whf_mux
);

  typedef struct packed {
    logic [4:0]       rdst;
    logic             valid;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t hist_q [DEPTH];
  entry_t live;

  // Writes to r0 are architecturally discarded, so they never become valid.
  always_comb begin
    live.rdst  = i_whf_rdst;
    live.valid = i_whf_reg_write_rf && (i_whf_rdst != 5'd0);
    live.data  = i_whf_mux;
  end

  // NOTE: the history is a small register array, not a RAM, so every field is
  // reset to keep lookups and stage-0 outputs free of X; state uses <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) hist_q[k] <= '0;
    end else if (i_whf_flush) begin
      for (int k = 0; k < DEPTH; k++) hist_q[k].valid <= 1'b0;
    end else if (!i_whf_stall) begin
      hist_q[0] <= live;
      for (int k = 1; k < DEPTH; k++) hist_q[k] <= hist_q[k-1];
    end
  end

  // Candidates are scanned oldest to youngest so the youngest match overwrites
  // any older shadowed copy; the live WB bus is scanned last when bypassing.
  // NOTE: hit/data get defaults before the loops so no latch is inferred.
  always_comb begin
    o_whf_hit  = '0;
    o_whf_data = '0;
    for (int p = 0; p < NREAD; p++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hist_q[k].valid && (hist_q[k].rdst == i_whf_rs[p*5 +: 5])) begin
          o_whf_hit[p]                 = 1'b1;
          o_whf_data[p*WIDTH +: WIDTH] = hist_q[k].data;
        end
      end
      if (BYPASS && live.valid && (live.rdst == i_whf_rs[p*5 +: 5])) begin
        o_whf_hit[p]                 = 1'b1;
        o_whf_data[p*WIDTH +: WIDTH] = live.data;
      end
      if (i_whf_rs[p*5 +: 5] == 5'd0) begin
        o_whf_hit[p]                 = 1'b0;
        o_whf_data[p*WIDTH +: WIDTH] = '0;
      end
    end
  end

  // Stage-0 fields reproduce the legacy one-cycle-late writeback register.
  assign o_whf_rdst         = hist_q[0].rdst;
  assign o_whf_reg_write_rf = hist_q[0].valid;
  assign o_whf_mux          = hist_q[0].data;

endmodule

// File: tb/tb_wb_history_fwd.sv
// Bench for wb_history_fwd: two instances (BYPASS=0 and BYPASS=1) share one
// stimulus stream and are compared against a queue-based history model.
module tb_wb_history_fwd;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int NREAD = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   stall, flush, we;
  logic [4:0]             rdst;
  logic [WIDTH-1:0]       mux;
  logic [NREAD*5-1:0]     rs;

  logic [NREAD-1:0]       hit0, hit1;
  logic [NREAD*WIDTH-1:0] data0, data1;
  logic [4:0]             ordst0, ordst1;
  logic                   owe0, owe1;
  logic [WIDTH-1:0]       omux0, omux1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_history_fwd #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_whf_stall(stall), .i_whf_flush(flush),
    .i_whf_rdst(rdst), .i_whf_reg_write_rf(we), .i_whf_mux(mux), .i_whf_rs(rs),
    .o_whf_hit(hit0), .o_whf_data(data0), .o_whf_rdst(ordst0),
    .o_whf_reg_write_rf(owe0), .o_whf_mux(omux0)
  );

  wb_history_fwd #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_whf_stall(stall), .i_whf_flush(flush),
    .i_whf_rdst(rdst), .i_whf_reg_write_rf(we), .i_whf_mux(mux), .i_whf_rs(rs),
    .o_whf_hit(hit1), .o_whf_data(data1), .o_whf_rdst(ordst1),
    .o_whf_reg_write_rf(owe1), .o_whf_mux(omux1)
  );

  // Reference model: a list of retired writebacks, youngest at the front.
  typedef struct {
    logic [4:0]       rdst;
    bit               v;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t hist[$];

  function automatic void model_reset();
    hist.delete();
    repeat (DEPTH) hist.push_back('{rdst: 5'd0, v: 1'b0, data: '0});
  endfunction

  function automatic void model_edge();
    ent_t dropped;
    if (flush) begin
      foreach (hist[i]) hist[i].v = 1'b0;
    end else if (!stall) begin
      hist.push_front('{rdst: rdst, v: (we && rdst != 5'd0), data: mux});
      dropped = hist.pop_back();
    end
  endfunction

  function automatic bit model_lookup(input bit byp, input logic [4:0] r,
                                     output logic [WIDTH-1:0] d);
    d = '0;
    if (r == 5'd0) return 1'b0;
    if (byp && we && rdst != 5'd0 && rdst == r) begin
      d = mux;
      return 1'b1;
    end
    foreach (hist[i]) begin
      if (hist[i].v && hist[i].rdst == r) begin
        d = hist[i].data;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic cmp(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Compare both instances against the model for the current inputs/state.
  task automatic check_all(input string tag);
    logic [WIDTH-1:0] ed;
    bit eh;
    for (int p = 0; p < NREAD; p++) begin
      eh = model_lookup(1'b0, rs[p*5 +: 5], ed);
      cmp($sformatf("%s d0 hit%0d", tag, p), {31'd0, hit0[p]}, {31'd0, eh});
      cmp($sformatf("%s d0 data%0d", tag, p), data0[p*WIDTH +: WIDTH], ed);
      eh = model_lookup(1'b1, rs[p*5 +: 5], ed);
      cmp($sformatf("%s d1 hit%0d", tag, p), {31'd0, hit1[p]}, {31'd0, eh});
      cmp($sformatf("%s d1 data%0d", tag, p), data1[p*WIDTH +: WIDTH], ed);
    end
    cmp({tag, " d0 we"}, {31'd0, owe0}, {31'd0, hist[0].v});
    cmp({tag, " d1 we"}, {31'd0, owe1}, {31'd0, hist[0].v});
    if (hist[0].v) begin
      cmp({tag, " d0 rdst"}, {27'd0, ordst0}, {27'd0, hist[0].rdst});
      cmp({tag, " d0 mux"}, omux0, hist[0].data);
      cmp({tag, " d1 rdst"}, {27'd0, ordst1}, {27'd0, hist[0].rdst});
      cmp({tag, " d1 mux"}, omux1, hist[0].data);
    end
  endtask

  // One clock edge with the inputs currently applied; returns at the next negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [4:0] d, input logic [WIDTH-1:0] v,
                       input logic [4:0] r0, input logic [4:0] r1, input string tag);
    we = w; rdst = d; mux = v; rs = {r1, r0};
    #1 check_all(tag);
  endtask

  task automatic wr(input logic [4:0] d, input logic [WIDTH-1:0] v, input string tag);
    drive(1'b1, d, v, d, 5'd0, tag);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; we = 1'b0; rdst = '0; mux = '0; rs = '0;
    model_reset();

    // Power-on reset state.
    #1 check_all("por");
    cmp("por rdst", {27'd0, ordst0}, 32'd0);
    cmp("por mux", omux0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Shift/age: r3, r4, r7 one per cycle.
    wr(5'd3, 32'hA, "age w3");
    wr(5'd4, 32'hB, "age w4");
    wr(5'd7, 32'hC, "age w7");
    drive(1'b0, 5'd0, '0, 5'd4, 5'd7, "age rd");
    cmp("age rs4 hit", {31'd0, hit0[0]}, 32'd1);
    cmp("age rs4 data", data0[0 +: WIDTH], 32'hB);
    cmp("age rs7 data", data0[WIDTH +: WIDTH], 32'hC);
    drive(1'b0, 5'd0, '0, 5'd3, 5'd3, "age rd3");
    cmp("age rs3 miss", {30'd0, hit0}, 32'd0);

    // Priority: youngest copy of r5 shadows the older one until it ages out.
    wr(5'd5, 32'h11, "pri w1");
    wr(5'd5, 32'h22, "pri w2");
    drive(1'b0, 5'd0, '0, 5'd5, 5'd5, "pri rd");
    cmp("pri young", data0[0 +: WIDTH], 32'h22);
    wr(5'd8, 32'h33, "pri w3");
    drive(1'b0, 5'd0, '0, 5'd5, 5'd0, "pri rd2");
    cmp("pri aged", data0[0 +: WIDTH], 32'h22);
    for (int i = 0; i < DEPTH; i++) wr(5'(9 + i), 32'(i), "pri fill");
    drive(1'b0, 5'd0, '0, 5'd5, 5'd5, "pri rd3");
    cmp("pri gone", {30'd0, hit0}, 32'd0);

    // Async reset mid-cycle with r5 loaded.
    wr(5'd5, 32'h55, "rst ld");
    drive(1'b0, 5'd0, '0, 5'd5, 5'd5, "rst pre");
    cmp("rst pre hit", {31'd0, hit0[0]}, 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("rst mid");
    cmp("rst hit", {30'd0, hit0 | hit1}, 32'd0);
    cmp("rst we", {31'd0, owe0}, 32'd0);
    cmp("rst rdst", {27'd0, ordst0}, 32'd0);
    cmp("rst mux", omux0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr(5'd2, 32'h77, "rst first");
    drive(1'b0, 5'd0, '0, 5'd2, 5'd0, "rst cap");
    cmp("rst cap data", data0[0 +: WIDTH], 32'h77);

    // Stall holds history for 3 cycles; stall+flush invalidates everything.
    wr(5'd10, 32'h100, "st w10");
    wr(5'd11, 32'h200, "st w11");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(12 + i), 32'(i + 1), 5'd10, 5'd11, "st hold");
      tick();
    end
    drive(1'b0, 5'd0, '0, 5'd10, 5'd11, "st rd");
    cmp("st r10", data0[0 +: WIDTH], 32'h100);
    cmp("st r11", data0[WIDTH +: WIDTH], 32'h200);
    flush = 1'b1;
    drive(1'b1, 5'd13, 32'h5, 5'd10, 5'd11, "fl pre");
    tick();
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, '0, 5'd10, 5'd11, "fl rd");
    cmp("fl hits", {30'd0, hit0 | hit1}, 32'd0);

    // r0 writes and disabled writes never become valid.
    wr(5'd0, 32'hFF, "r0 w");
    drive(1'b0, 5'd6, 32'h66, 5'd0, 5'd6, "dis w");
    tick();
    drive(1'b0, 5'd0, '0, 5'd0, 5'd6, "r0 rd");
    cmp("r0 hits", {30'd0, hit0 | hit1}, 32'd0);
    cmp("r0 we", {31'd0, owe0}, 32'd0);

    // Bypass: live write beats entry 0 on the BYPASS=1 instance only.
    wr(5'd9, 32'h1, "byp w");
    drive(1'b1, 5'd9, 32'h2, 5'd9, 5'd9, "byp live");
    cmp("byp d1 p0", data1[0 +: WIDTH], 32'h2);
    cmp("byp d1 p1", data1[WIDTH +: WIDTH], 32'h2);
    cmp("byp d0 p0", data0[0 +: WIDTH], 32'h1);
    drive(1'b0, 5'd9, 32'h2, 5'd9, 5'd9, "byp drop");
    cmp("byp drop p0", data1[0 +: WIDTH], 32'h1);
    cmp("byp drop p1", data1[WIDTH +: WIDTH], 32'h1);

    // Randomized traffic over a small register range to force collisions.
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "rand");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
